uart_rx_ctrl: RTL and testbench

//  Receive-side frame controller for the UART RX path. Sits beside the edge/bit counter:

---
 rtl/uart_rx_pkg.sv | 49 ++++
 rtl/uart_rx_ctrl_sampler.sv | 42 ++++
 rtl/uart_rx_ctrl.sv | 140 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the UART RX frame controller.
// Optional build macro: UART_RX_MAJORITY_SAMPLE_EN (3-sample majority vote per bit).
package uart_rx_pkg;

    localparam int unsigned PRESCALAR_WIDTH_DEF = 4;
    localparam int unsigned BIT_COUNT_WIDTH_DEF = 4;
    localparam int unsigned DATA_WIDTH_DEF      = 8;
    localparam int unsigned PRESCALE            = 2 ** PRESCALAR_WIDTH_DEF;
    localparam int unsigned SP                  = PRESCALE / 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_FLUSH
    } rx_state_e;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_type_e;

    // Control outputs toward the edge/bit counter, decoded from state
    typedef struct packed {
        logic enable;
        logic disable_bit_count;
        logic busy;
    } rx_ctrl_t;

    // Mid-bit sample point for a given edge counter width
    function automatic int unsigned sample_point(input int unsigned pw);
        return (32'd1 << pw) / 32'd2;
    endfunction

    // Moore decode of the controller state
    function automatic rx_ctrl_t ctrl_of(input rx_state_e s);
        rx_ctrl_t c;
        c = '{enable: 1'b1, disable_bit_count: 1'b0, busy: 1'b1};
        case (s)
            ST_IDLE:  c = '{enable: 1'b0, disable_bit_count: 1'b1, busy: 1'b0};
            ST_FLUSH: c = '{enable: 1'b1, disable_bit_count: 1'b1, busy: 1'b1};
            default:  c = '{enable: 1'b1, disable_bit_count: 1'b0, busy: 1'b1};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_sampler.sv
// Bit sampler: produces the sampled bit value and the point at which it is valid.
// UART_RX_MAJORITY_SAMPLE_EN: majority of SP-1, SP, SP+1, valid at SP+1; otherwise single sample at SP.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALAR_WIDTH = PRESCALAR_WIDTH_DEF
) (
`ifdef UART_RX_MAJORITY_SAMPLE_EN
    input  logic                       clk,
    input  logic                       rst,
`endif
    input  logic                       rx_in,
    input  logic [PRESCALAR_WIDTH-1:0] edge_count,
    output logic                       sample_bit_c,
    output logic                       sample_done_c
);

    localparam int unsigned SP_L = sample_point(PRESCALAR_WIDTH);

`ifdef UART_RX_MAJORITY_SAMPLE_EN
    logic s_early;
    logic s_mid;

    // Capture the two samples that precede the voting point
    always_ff @(posedge clk) begin
        if (!rst) begin
            s_early <= 1'b0;
            s_mid   <= 1'b0;
        end else begin
            if (edge_count == PRESCALAR_WIDTH'(SP_L - 1)) s_early <= rx_in;
            if (edge_count == PRESCALAR_WIDTH'(SP_L))     s_mid   <= rx_in;
        end
    end

    assign sample_done_c = (edge_count == PRESCALAR_WIDTH'(SP_L + 1));
    assign sample_bit_c  = (s_early & s_mid) | (s_early & rx_in) | (s_mid & rx_in);
`else
    assign sample_done_c = (edge_count == PRESCALAR_WIDTH'(SP_L));
    assign sample_bit_c  = rx_in;
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: start detect, LSB-first deserialise, parity/stop check, result strobes.
// Optional build macro: UART_RX_MAJORITY_SAMPLE_EN (majority-vote bit sampling in uart_rx_sampler).
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALAR_WIDTH = PRESCALAR_WIDTH_DEF,
    parameter int unsigned BIT_COUNT_WIDTH = BIT_COUNT_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_in,
    input  logic                       par_en,
    input  logic                       par_type,
    input  logic [PRESCALAR_WIDTH-1:0] edge_count,
    input  logic [BIT_COUNT_WIDTH-1:0] bit_count,
    output logic                       enable,
    output logic                       disable_bit_count,
    output logic [DATA_WIDTH-1:0]      p_data,
    output logic                       data_valid,
    output logic                       parity_error,
    output logic                       stop_error,
    output logic                       busy
);

    rx_state_e             state;
    rx_ctrl_t              ctrl_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_en_q;
    par_type_e             par_type_q;
    logic                  par_err_q;
    logic                  stop_err_q;
    logic                  sample_bit_c;
    logic                  sample_done_c;
    logic                  boundary_c;
    logic                  exp_par_c;

    uart_rx_sampler #(
        .PRESCALAR_WIDTH(PRESCALAR_WIDTH)
    ) u_sampler (
`ifdef UART_RX_MAJORITY_SAMPLE_EN
        .clk          (clk),
        .rst          (rst),
`endif
        .rx_in        (rx_in),
        .edge_count   (edge_count),
        .sample_bit_c (sample_bit_c),
        .sample_done_c(sample_done_c)
    );

    assign boundary_c = (edge_count == {PRESCALAR_WIDTH{1'b1}});
    assign exp_par_c  = (^shift_q) ^ (par_type_q == PAR_ODD);

    assign enable            = ctrl_q.enable;
    assign disable_bit_count = ctrl_q.disable_bit_count;
    assign busy              = ctrl_q.busy;

    // Frame FSM with registered counter controls, datapath and result strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            ctrl_q       <= ctrl_of(ST_IDLE);
            shift_q      <= '0;
            p_data       <= '0;
            par_en_q     <= 1'b0;
            par_type_q   <= PAR_EVEN;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_in) begin
                        state      <= ST_START;
                        ctrl_q     <= ctrl_of(ST_START);
                        par_en_q   <= par_en;
                        par_type_q <= par_type_e'(par_type);
                        par_err_q  <= 1'b0;
                        stop_err_q <= 1'b0;
                    end
                end
                ST_START: begin
                    // A high start-bit sample is line noise, not a frame
                    if (sample_done_c && sample_bit_c) begin
                        state  <= ST_FLUSH;
                        ctrl_q <= ctrl_of(ST_FLUSH);
                    end else if (boundary_c) begin
                        state  <= ST_DATA;
                        ctrl_q <= ctrl_of(ST_DATA);
                    end
                end
                ST_DATA: begin
                    if (sample_done_c) shift_q <= {sample_bit_c, shift_q[DATA_WIDTH-1:1]};
                    if (boundary_c && bit_count == BIT_COUNT_WIDTH'(DATA_WIDTH)) begin
                        state  <= par_en_q ? ST_PARITY : ST_STOP;
                        ctrl_q <= ctrl_of(par_en_q ? ST_PARITY : ST_STOP);
                    end
                end
                ST_PARITY: begin
                    if (sample_done_c) par_err_q <= (sample_bit_c != exp_par_c);
                    if (boundary_c) begin
                        state  <= ST_STOP;
                        ctrl_q <= ctrl_of(ST_STOP);
                    end
                end
                ST_STOP: begin
                    if (sample_done_c) stop_err_q <= !sample_bit_c;
                    if (boundary_c) begin
                        state  <= ST_IDLE;
                        ctrl_q <= ctrl_of(ST_IDLE);
                        if (!par_err_q && !stop_err_q) begin
                            data_valid <= 1'b1;
                            p_data     <= shift_q;
                        end else begin
                            parity_error <= par_err_q;
                            stop_error   <= stop_err_q;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Let the edge counter wrap to zero before re-arming
                    if (boundary_c) begin
                        state  <= ST_IDLE;
                        ctrl_q <= ctrl_of(ST_IDLE);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    ctrl_q <= ctrl_of(ST_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl with a behavioural edge/bit counter beside it.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int unsigned PW = PRESCALAR_WIDTH_DEF;
    localparam int unsigned BW = BIT_COUNT_WIDTH_DEF;
    localparam int unsigned DW = DATA_WIDTH_DEF;

    typedef struct {
        logic [2:0] flags;  // {data_valid, parity_error, stop_error}
        logic [7:0] data;
        int         cyc;    // absolute cycle of the strobe, 0 = not checked
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_line;
    logic          glitch_en;
    logic          rx_in;
    logic          par_en;
    logic          par_type;
    logic [PW-1:0] edge_count;
    logic [BW-1:0] bit_count;
    logic          enable;
    logic          disable_bit_count;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          parity_error;
    logic          stop_error;
    logic          busy;

    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t q[$];

    uart_rx_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .rx_in            (rx_in),
        .par_en           (par_en),
        .par_type         (par_type),
        .edge_count       (edge_count),
        .bit_count        (bit_count),
        .enable           (enable),
        .disable_bit_count(disable_bit_count),
        .p_data           (p_data),
        .data_valid       (data_valid),
        .parity_error     (parity_error),
        .stop_error       (stop_error),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge/bit counter companion block
    always @(posedge clk) begin
        if (!rst) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else begin
            if (!enable) edge_count <= '0;
            else         edge_count <= edge_count + 1'b1;
            if (disable_bit_count) bit_count <= '0;
            else if (enable && edge_count == {PW{1'b1}}) bit_count <= bit_count + 1'b1;
        end
    end

    // Optional one-cycle flip of the line at SP-1 (only matters to a majority-vote sampler)
    assign rx_in = rx_line ^ (glitch_en & enable & (edge_count == PW'(SP - 1)));

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every strobe cycle pops one expectation
    always @(negedge clk) begin
        if (rst && (data_valid || parity_error || stop_error)) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", {data_valid, parity_error, stop_error}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("strobe_flags", {data_valid, parity_error, stop_error}, e.flags);
                chk("p_data", p_data, e.data);
                if (e.cyc != 0) chk("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx_line = b;
        repeat (PRESCALE) @(posedge clk);
        #1;
    endtask

    // One frame, LSB first; optionally registers the expected result with its strobe cycle
    task automatic send_frame(input logic [7:0] d, input bit with_par, input bit par_bit,
                              input bit stop_bit, input bit push, input logic [2:0] ef,
                              input logic [7:0] ed, input int lat);
        exp_t e;
        @(posedge clk);
        #1;
        if (push) begin
            e.flags = ef;
            e.data  = ed;
            e.cyc   = (lat > 0) ? cyc + lat : 0;
            q.push_back(e);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (with_par) drive_bit(par_bit);
        drive_bit(stop_bit);
        rx_line = 1'b1;
    endtask

    task automatic wait_busy_low(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("busy_fall_in_time", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; rx_line = 1'b1; glitch_en = 1'b0; par_en = 1'b0; par_type = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_enable", enable, 0);
        chk("reset_disable_bit_count", disable_bit_count, 1);
        chk("reset_busy", busy, 0);
        chk("reset_p_data", p_data, 0);
        chk("reset_strobes", {data_valid, parity_error, stop_error}, 0);
        rst = 1'b1;
        repeat (5) @(posedge clk);

        // Plain 8N1: start fall driven at c, strobe at c+1+16*10
        send_frame(8'hA5, 0, 0, 1, 1, 3'b100, 8'hA5, 161);
        repeat (10) @(posedge clk);

        // Even parity, correct bit; mid-frame config changes are ignored
        par_en = 1'b1; par_type = 1'b0;
        fork
            send_frame(8'h3C, 1, 0, 1, 1, 3'b100, 8'h3C, 177);
            begin
                repeat (40) @(posedge clk);
                #1;
                par_en = 1'b0; par_type = 1'b1;
            end
        join
        par_en = 1'b1; par_type = 1'b0;
        repeat (10) @(posedge clk);

        // Even parity, wrong bit: parity_error only, p_data keeps 0x3C
        send_frame(8'h0F, 1, 1, 1, 1, 3'b010, 8'h3C, 177);
        repeat (10) @(posedge clk);

        // Odd parity: 0x01 has one set bit, so parity bit 0
        par_type = 1'b1;
        send_frame(8'h01, 1, 0, 1, 1, 3'b100, 8'h01, 177);
        repeat (10) @(posedge clk);

        // Stop bit low: stop_error only, then a normal frame
        par_en = 1'b0; par_type = 1'b0;
        send_frame(8'h0F, 0, 0, 0, 1, 3'b001, 8'h01, 161);
        repeat (10) @(posedge clk);
        send_frame(8'h55, 0, 0, 1, 1, 3'b100, 8'h55, 161);
        repeat (10) @(posedge clk);

        // Both errors in one frame
        par_en = 1'b1;
        send_frame(8'h0F, 1, 1, 0, 1, 3'b011, 8'h55, 177);
        par_en = 1'b0;
        repeat (10) @(posedge clk);

        // Start-bit glitch: low 4 cycles, then flush back to idle with counter wrapped
        @(posedge clk);
        #1;
        rx_line = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_line = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy_high", busy, 1);
        wait_busy_low(40);
        chk("flush_edge_count_zero", edge_count, 0);
        chk("flush_enable_low", enable, 0);
        chk("flush_disable_bit_count", disable_bit_count, 1);
        repeat (10) @(posedge clk);

        // Reset during data bit 4 of an all-ones frame
        fork
            send_frame(8'hFF, 0, 0, 1, 0, 3'b000, 8'h00, 0);
            begin
                repeat (88) @(posedge clk);
                #1;
                chk("busy_before_reset", busy, 1);
                rst = 1'b0;
                @(posedge clk);
                #1;
                chk("rst_enable", enable, 0);
                chk("rst_disable_bit_count", disable_bit_count, 1);
                chk("rst_busy", busy, 0);
                chk("rst_p_data", p_data, 0);
                rst = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        send_frame(8'h81, 0, 0, 1, 1, 3'b100, 8'h81, 161);
        repeat (10) @(posedge clk);

        // Back-to-back frames: second start fall meets the single IDLE cycle, so the
        // strobes are 161 cycles apart (160 cycles between them)
        glitch_en = 1'b1;
        send_frame(8'h12, 0, 0, 1, 1, 3'b100, 8'h12, 161);
        send_frame(8'h34, 0, 0, 1, 1, 3'b100, 8'h34, 161);
        glitch_en = 1'b0;

        for (int n = 0; n < 400 && q.size() != 0; n++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
